// File: rtl/stream_to_2phase_tx.sv
// Stream-to-2-phase bundled-data transmitter.
// Each accepted stream word toggles async_req_o once. async_data_o is held
// stable until the synchronised acknowledge phase matches the request phase.
// Integration note: the data register to receiver capture path must be
// constrained (max-delay) shorter than the req path plus the receiver
// synchroniser delay, so the data settles before the receiver sees the req edge.
module stream_to_2phase_tx #(
  parameter type T              = logic,
  parameter int  SYNC_STAGES    = 2,
  parameter int  TIMEOUT_CYCLES = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  T     data_i,
  input  logic valid_i,
  output logic ready_o,
  output logic async_req_o,
  output T     async_data_o,
  input  logic async_ack_i,
  output logic busy_o,
  output logic timeout_o
);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic                   req_q, req_d;
  T                       data_q, data_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_sync;
  logic                   handshake;

  assign ack_sync  = sync_q[SYNC_STAGES-1];
  // ready_o depends only on state, so handshake has no path from ack
  assign handshake = valid_i && (state_q == IDLE);

  assign ready_o      = (state_q == IDLE);
  assign busy_o       = (state_q == WAIT_ACK);
  assign async_req_o  = req_q;
  assign async_data_o = data_q;

  // Acknowledge synchroniser: stage 0 samples the asynchronous input
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_ack_i};
    end
  end

  // Next-state logic: accept in IDLE, wait for ack phase to match req phase
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          data_d  = data_i;
          req_d   = ~req_q;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_sync == req_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request phase and bundled data registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
    end
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

      logic [CW-1:0] cnt_q, cnt_d;
      logic          to_q, to_d;

      // Count cycles spent waiting; flag sticks once the limit is reached
      always_comb begin
        cnt_d = cnt_q;
        to_d  = to_q;
        if (handshake) begin
          cnt_d = '0;
        end else if ((state_q == WAIT_ACK) && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + CW'(1);
        end
        if ((state_q == WAIT_ACK) && (cnt_d == CNT_MAX)) begin
          to_d = 1'b1;
        end
      end

      // Timeout counter and sticky flag registers
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          cnt_q <= '0;
          to_q  <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          to_q  <= to_d;
        end
      end

      assign timeout_o = to_q;
    end else begin : g_no_timeout
      assign timeout_o = 1'b0;
    end
  endgenerate

endmodule
